// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the register access sequencer: FSM states,
// the queued request record and the read/write op encoding.
package reg_seq_pkg;

  localparam int REQ_DATA_W         = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [REQ_DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/seq_fifo.sv
// In-order request buffer. Full is registered from the next count so the
// upstream ready never has a combinational path from the pop side.
module seq_fifo
  import reg_seq_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  req_t                     push_data,
  input  logic                     pop,
  output req_t                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_t               mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               do_push, do_pop;

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/reg_access_sequencer.sv
// Front-end for the single-port data register: buffers requests, issues them one
// at a time, and returns read data on a valid/ready response channel.
module reg_access_sequencer
  import reg_seq_pkg::*;
#(
  parameter int DATA_W     = REQ_DATA_W,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              reg_we,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // source holds its payload stable while valid is high and ready is low.

  req_t                         push_req, head_req;
  logic                         pop, fifo_full, fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;

  state_e              state_q, state_d;
  logic                reg_we_q, reg_we_d;
  logic                reg_re_q, reg_re_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

  always_comb begin
    push_req       = '0;
    push_req.write = req_write;
    push_req.data  = req_wdata;
  end

  seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Strobes are computed from the next state so each one lines up exactly with
  // the state that owns it and all three are mutually exclusive by construction.
  always_comb begin
    state_d      = state_q;
    pop          = 1'b0;
    reg_we_d     = 1'b0;
    reg_wdata_d  = '0;
    reg_re_d     = 1'b0;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_req.write == OP_WRITE) begin
            state_d     = WRITE;
            reg_we_d    = 1'b1;
            reg_wdata_d = head_req.data;
          end else begin
            state_d  = READ;
            reg_re_d = 1'b1;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = reg_rdata;
      end
      RESP: begin
        // The FIFO stays untouched here so responses come back in request order.
        if (resp_ready) state_d = IDLE;
        else            resp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      reg_we_q     <= 1'b0;
      reg_wdata_q  <= '0;
      reg_re_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      reg_we_q     <= reg_we_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_re_q     <= reg_re_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = !fifo_full;
  assign reg_we     = reg_we_q;
  assign reg_wdata  = reg_wdata_q;
  assign reg_re     = reg_re_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign busy       = (state_q != IDLE) || (fifo_count != '0);

endmodule
